// File: rtl/mcdp_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset core: opcodes, functs, FSM states, ALU ops.
// Optional build macro MCDP_EXT_OPS_EN makes bne and ori legal instructions.
package mcdp_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic rtype;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic addi;
    logic ori;
    logic j;
    logic legal;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: c.rtype = fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_LW:    c.lw    = 1'b1;
      OP_SW:    c.sw    = 1'b1;
      OP_BEQ:   c.beq   = 1'b1;
      OP_ADDI:  c.addi  = 1'b1;
      OP_J:     c.j     = 1'b1;
`ifdef MCDP_EXT_OPS_EN
      OP_BNE:   c.bne   = 1'b1;
      OP_ORI:   c.ori   = 1'b1;
`endif
      default:  ;
    endcase
    c.legal = |{c.rtype, c.lw, c.sw, c.beq, c.bne, c.addi, c.ori, c.j};
    return c;
  endfunction

  function automatic alu_op_t funct_op(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mcdp_alu.sv
// Combinational ALU shared by address, branch-compare and arithmetic cycles.
module mcdp_alu
  import mcdp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  always_comb begin
    y = '0;
    case (op)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/mcdp_core.sv
// Multi-cycle MIPS-subset core: FSM controller, register file and datapath on one memory port.
// Build macro MCDP_EXT_OPS_EN adds bne/ori; without it those opcodes halt the core.
module mcdp_core
  import mcdp_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc,
  output logic            instr_retired,
  output logic            halt
);

  localparam int RW = $clog2(NREGS);

  state_t          state, state_d;
  logic [31:0]     ir;
  logic [XLEN-1:0] a_q, b_q, alu_out, mdr;
  logic [XLEN-1:0] rf [NREGS];
  ctrl_t           ctl;
  logic [4:0]      rs, rt, rd, wb_idx;
  logic [XLEN-1:0] imm_sx, imm_zx, rs_val, rt_val, wb_val;
  logic [XLEN-1:0] pc_d, addr_d, wdata_d, j_tgt, br_tgt;
  logic [XLEN-1:0] alu_b, alu_y;
  alu_op_t         alu_op;
  logic            alu_zero, req_d, we_d, retire, mem_done, br_taken, wb_en;

  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign ctl      = decode(ir[31:26], ir[5:0]);
  assign imm_sx   = {{(XLEN-16){ir[15]}}, ir[15:0]};
  assign imm_zx   = {{(XLEN-16){1'b0}}, ir[15:0]};
  assign mem_done = mem_req & mem_ready;
  // pc already points past this instruction when these are used
  assign j_tgt    = {pc[XLEN-1:28], ir[25:0], 2'b00};
  assign br_tgt   = pc + (imm_sx << 2);
  assign br_taken = (ctl.beq & alu_zero) | (ctl.bne & ~alu_zero);

  // $0 and indices beyond the implemented file read as zero and ignore writes
  function automatic logic in_range(input logic [4:0] idx);
    return (idx != 5'd0) && (int'(idx) < NREGS);
  endfunction

  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (in_range(rs)) rs_val = rf[rs[RW-1:0]];
    if (in_range(rt)) rt_val = rf[rt[RW-1:0]];
  end

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = imm_sx;
    if (ctl.rtype) begin
      alu_op = funct_op(ir[5:0]);
      alu_b  = b_q;
    end else if (ctl.beq || ctl.bne) begin
      alu_op = ALU_SUB;
      alu_b  = b_q;
    end else if (ctl.ori) begin
      alu_op = ALU_OR;
      alu_b  = imm_zx;
    end
  end

  mcdp_alu #(.XLEN(XLEN)) u_alu (
    .a    (a_q),
    .b    (alu_b),
    .op   (alu_op),
    .y    (alu_y),
    .zero (alu_zero)
  );

  always_comb begin
    state_d = state;
    pc_d    = pc;
    retire  = 1'b0;
    case (state)
      ST_FETCH:
        if (mem_done) begin
          state_d = ST_DECODE;
          pc_d    = pc + XLEN'(4);
        end
      ST_DECODE:
        if (!ctl.legal) state_d = ST_HALT;
        else if (ctl.j) begin
          pc_d    = j_tgt;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else state_d = ST_EXEC;
      ST_EXEC:
        if (ctl.beq || ctl.bne) begin
          if (br_taken) pc_d = br_tgt;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (ctl.lw || ctl.sw) state_d = ST_MEM;
        else state_d = ST_WB;
      ST_MEM:
        if (mem_done) begin
          if (ctl.sw) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else state_d = ST_WB;
        end
      ST_WB: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_HALT;
    endcase

    // Request outputs are registered from the next state so they hold steady across waits
    req_d   = (state_d == ST_FETCH) || (state_d == ST_MEM);
    we_d    = (state_d == ST_MEM) && ctl.sw;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    if (state_d == ST_FETCH) addr_d = pc_d;
    else if (state_d == ST_MEM && state == ST_EXEC) begin
      addr_d = alu_y;
      if (ctl.sw) wdata_d = b_q;
    end
  end

  assign wb_idx = ctl.rtype ? rd : rt;
  assign wb_val = ctl.lw ? mdr : alu_out;
  assign wb_en  = (state == ST_WB) && in_range(wb_idx);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      if (state == ST_FETCH && mem_done) ir <= mem_rdata[31:0];
      if (state == ST_DECODE) begin
        a_q <= rs_val;
        b_q <= rt_val;
      end
      if (state == ST_EXEC) alu_out <= alu_y;
      if (state == ST_MEM && mem_done) mdr <= mem_rdata;
      if (wb_en) rf[wb_idx[RW-1:0]] <= wb_val;
    end
  end

  assign instr_retired = retire;
  assign halt          = (state == ST_HALT);

endmodule
